// File: rtl/jmod_arbiter_if.sv
// Requester-side bus of the shared j mod t engine: request/operand inputs
// plus grant, done and result return path.
interface jmod_arbiter_if #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned W     = 5,
   parameter int unsigned ID_W  = 2
);
   logic [N_REQ-1:0]   req;
   logic [N_REQ*W-1:0] j_in;
   logic [N_REQ*W-1:0] t_in;
   logic [N_REQ-1:0]   grant;
   logic               busy;
   logic               done;
   logic [ID_W-1:0]    done_id;
   logic [W-1:0]       result;
   logic               err;

   modport master (
      output req, j_in, t_in,
      input  grant, busy, done, done_id, result, err
   );

   modport slave (
      input  req, j_in, t_in,
      output grant, busy, done, done_id, result, err
   );
endinterface

// File: rtl/jmod_arbiter.sv
// Round-robin arbiter in front of one iterative modular-reduction engine
// (result = j mod t by repeated subtraction), shared by the twiddle-index
// requesters of the 8-point NTT twiddle generator.
module jmod_arbiter #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned W     = 5,
   parameter int unsigned ID_W  = 2
) (
   input  logic          clock,
   input  logic          reset,
   jmod_arbiter_if.slave io
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SUB  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state,     state_n;
   logic [W-1:0]      acc,       acc_n;
   logic [W-1:0]      tr,        tr_n;
   logic [ID_W-1:0]   cur_id,    cur_id_n;
   logic [ID_W-1:0]   ptr,       ptr_n;
   logic [N_REQ-1:0]  grant_q,   grant_n;
   logic              done_q,    done_n;
   logic [ID_W-1:0]   done_id_q, done_id_n;
   logic [W-1:0]      result_q,  result_n;
   logic              err_q,     err_n;

   logic              found;
   logic [ID_W-1:0]   pick_id;
   logic [ID_W-1:0]   idx;
   logic [W-1:0]      j_sel;
   logic [W-1:0]      t_sel;

   // Rotating priority search: first set req bit starting at ptr, wrapping mod N_REQ.
   always_comb begin
      found   = 1'b0;
      pick_id = '0;
      idx     = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         idx = ID_W'((32'(ptr) + k) % N_REQ);
         if (!found && io.req[idx]) begin
            found   = 1'b1;
            pick_id = idx;
         end
      end
      j_sel = io.j_in[32'(pick_id) * W +: W];
      t_sel = io.t_in[32'(pick_id) * W +: W];
   end

   // Next-state and next-output logic for arbitration and the subtract loop.
   always_comb begin
      state_n   = state;
      acc_n     = acc;
      tr_n      = tr;
      cur_id_n  = cur_id;
      ptr_n     = ptr;
      grant_n   = '0;
      done_n    = done_q;
      done_id_n = done_id_q;
      result_n  = result_q;
      err_n     = err_q;
      unique case (state)
         IDLE: begin
            if (found) begin
               grant_n  = N_REQ'(1) << pick_id;
               acc_n    = j_sel;
               tr_n     = t_sel;
               cur_id_n = pick_id;
               ptr_n    = ID_W'((32'(pick_id) + 1) % N_REQ);
               err_n    = 1'b0;
               if (t_sel == '0) begin
                  // Zero modulus short-circuits: report j unchanged with err.
                  state_n   = DONE;
                  done_n    = 1'b1;
                  result_n  = j_sel;
                  err_n     = 1'b1;
                  done_id_n = pick_id;
               end else begin
                  state_n = SUB;
               end
            end
         end
         SUB: begin
            if (acc >= tr) begin
               acc_n = acc - tr;
            end else begin
               result_n  = acc;
               done_id_n = cur_id;
               done_n    = 1'b1;
               state_n   = DONE;
            end
         end
         DONE: begin
            done_n  = 1'b0;
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // State and registered-output update; synchronous reset drops any in-flight request.
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         acc       <= '0;
         tr        <= '0;
         cur_id    <= '0;
         ptr       <= '0;
         grant_q   <= '0;
         done_q    <= 1'b0;
         done_id_q <= '0;
         result_q  <= '0;
         err_q     <= 1'b0;
      end else begin
         state     <= state_n;
         acc       <= acc_n;
         tr        <= tr_n;
         cur_id    <= cur_id_n;
         ptr       <= ptr_n;
         grant_q   <= grant_n;
         done_q    <= done_n;
         done_id_q <= done_id_n;
         result_q  <= result_n;
         err_q     <= err_n;
      end
   end

   assign io.grant   = grant_q;
   assign io.busy    = (state != IDLE);
   assign io.done    = done_q;
   assign io.done_id = done_id_q;
   assign io.result  = result_q;
   assign io.err     = err_q;

endmodule

// File: tb/tb_jmod_arbiter.sv
// Directed bench for jmod_arbiter with a scoreboard of expected results.
module tb_jmod_arbiter;

   localparam int unsigned NR = 4;
   localparam int unsigned WW = 5;
   localparam int unsigned IW = 2;

   typedef struct {
      int unsigned id;
      int unsigned res;
      int unsigned err;
      int unsigned lat;
   } exp_t;

   logic clock = 1'b0;
   logic reset = 1'b1;

   jmod_arbiter_if #(.N_REQ(NR), .W(WW), .ID_W(IW)) io ();

   jmod_arbiter #(.N_REQ(NR), .W(WW), .ID_W(IW)) dut (
      .clock (clock),
      .reset (reset),
      .io    (io)
   );

   always #5 clock = ~clock;

   int unsigned cyc    = 0;
   int unsigned last_g = 0;
   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;
   int unsigned n_fail   = 0;
   exp_t sb[$];

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input int unsigned id, input int unsigned j, input int unsigned t);
      exp_t e;
      e.id  = id;
      e.res = (t == 0) ? j : j % t;
      e.err = (t == 0) ? 1 : 0;
      e.lat = (t == 0) ? 0 : j / t + 1;
      return e;
   endfunction

   // Drive one requester and push its expected completion.
   task automatic post(input int unsigned id, input int unsigned j, input int unsigned t);
      io.req[id]            = 1'b1;
      io.j_in[id*WW +: WW]  = WW'(j);
      io.t_in[id*WW +: WW]  = WW'(t);
      sb.push_back(model(id, j, t));
   endtask

   task automatic wait_grant(input string tag, input logic [NR-1:0] exp,
                             output int unsigned gcyc, output logic err_at);
      int unsigned n = 0;
      while (io.grant == '0 && n < 200) begin
         @(posedge clock); #1;
         n++;
      end
      check(tag, 32'(io.grant), 32'(exp));
      check({tag, "_busy"}, 32'(io.busy), 32'd1);
      gcyc   = cyc;
      err_at = io.err;
      io.req = io.req & ~io.grant;
      @(posedge clock); #1;
      check({tag, "_pulse"}, 32'(io.grant), 32'd0);
   endtask

   task automatic drain(input string tag);
      int unsigned n = 0;
      while ((sb.size() != 0 || io.busy || io.done) && n < 200) begin
         @(posedge clock); #1;
         n++;
      end
      check(tag, 32'(sb.size()), 32'd0);
   endtask

   // Completion monitor: pops the scoreboard on every done pulse.
   always @(posedge clock) begin
      exp_t e;
      #1;
      if (io.grant != '0) last_g = cyc;
      if (io.done) begin
         if (sb.size() == 0) begin
            check("unexpected_done", 32'(io.done), 32'd0);
         end else begin
            e = sb.pop_front();
            check("done_id", 32'(io.done_id), e.id);
            check("result",  32'(io.result),  e.res);
            check("err",     32'(io.err),     e.err);
            check("latency", cyc - last_g,    e.lat);
            check("busy_done", 32'(io.busy),  32'd1);
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned g, gp;
      logic ea;
      io.req  = '0;
      io.j_in = '0;
      io.t_in = '0;
      repeat (3) @(posedge clock);
      #1;
      check("rst_grant",   32'(io.grant),   32'd0);
      check("rst_busy",    32'(io.busy),    32'd0);
      check("rst_done",    32'(io.done),    32'd0);
      check("rst_done_id", 32'(io.done_id), 32'd0);
      check("rst_result",  32'(io.result),  32'd0);
      check("rst_err",     32'(io.err),     32'd0);
      reset = 1'b0;
      @(posedge clock); #1;

      // Basic: 7 mod 3
      post(0, 7, 3);
      wait_grant("basic_grant", 4'b0001, g, ea);
      drain("basic_drain");

      // j < t: 2 mod 4 on requester 2
      post(2, 2, 4);
      wait_grant("jlt_grant", 4'b0100, g, ea);
      drain("jlt_drain");

      // Full contention from ptr=0
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      for (int i = 0; i < 4; i++) post(i, 9, 4);
      gp = 0;
      for (int i = 0; i < 4; i++) begin
         wait_grant($sformatf("cont_grant%0d", i), NR'(1) << i, g, ea);
         if (i > 0) check($sformatf("cont_gap%0d", i), g - gp, 32'd5);
         gp = g;
      end
      drain("cont_drain");

      // Round-robin: serve id 2, then 0 and 3 together
      post(2, 5, 7);
      wait_grant("rr_serve2", 4'b0100, g, ea);
      drain("rr_drain2");
      post(3, 10, 3);
      post(0, 4, 4);
      wait_grant("rr_first3", 4'b1000, g, ea);
      wait_grant("rr_then0", 4'b0001, g, ea);
      drain("rr_drain");

      // Zero modulus, then a normal request clears err
      post(1, 13, 0);
      wait_grant("zero_grant", 4'b0010, g, ea);
      check("zero_err_at_grant", 32'(ea), 32'd1);
      drain("zero_drain");
      post(1, 6, 5);
      wait_grant("errclr_grant", 4'b0010, g, ea);
      check("errclr_err", 32'(ea), 32'd0);
      drain("errclr_drain");

      // Reset mid-SUB discards the in-flight request
      io.req[0]          = 1'b1;
      io.j_in[0*WW +: WW] = WW'(31);
      io.t_in[0*WW +: WW] = WW'(1);
      wait_grant("rmid_grant", 4'b0001, g, ea);
      repeat (4) @(posedge clock);
      #1;
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      check("rmid_busy",   32'(io.busy),   32'd0);
      check("rmid_done",   32'(io.done),   32'd0);
      check("rmid_result", 32'(io.result), 32'd0);
      repeat (3) @(posedge clock);
      #1;
      post(0, 3, 2);
      post(1, 31, 1);
      wait_grant("rmid_ptr0", 4'b0001, g, ea);
      wait_grant("rmid_worst", 4'b0010, g, ea);
      drain("rmid_drain");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
